// File: rtl/shift_reg_piso_tx.sv
// Parallel-in serial-out transmitter with valid/ready load and frame markers.
// Optional even-parity trailer bit when PARITY_EN is defined.
module shift_reg_piso_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_e;
`else
  typedef enum logic {IDLE, SHIFT} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_data;
  logic             accept;
`ifdef PARITY_EN
  logic             par_q, par_d;
`endif

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    cnt_d     = cnt_q;
`ifdef PARITY_EN
    par_d     = par_q;
`endif
    last_data = (state_q == SHIFT) && (cnt_q == LAST);
    ser_valid = (state_q != IDLE);
    busy      = ser_valid;
    ser_first = (state_q == SHIFT) && (cnt_q == '0);
    ser_out   = 1'b0;
    if (state_q == SHIFT)
      ser_out = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
`ifdef PARITY_EN
    if (state_q == PAR)
      ser_out = par_q;
    ser_last  = (state_q == PAR);
`else
    ser_last  = last_data;
`endif
    load_ready = (state_q == IDLE) || ser_last;
    accept     = load_valid && load_ready;

    // Counter parks on the final data bit rather than wrapping.
    if ((state_q == SHIFT) && !last_data) begin
      cnt_d = cnt_q + CW'(1);
      if (MSB_FIRST)
        sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
      else
        sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
    end
`ifdef PARITY_EN
    if (last_data)
      state_d = PAR;
`endif
    if (load_ready)
      state_d = accept ? SHIFT : IDLE;
    if (accept) begin
      sreg_d = data_in;
      cnt_d  = '0;
`ifdef PARITY_EN
      par_d  = ^data_in;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
`ifdef PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
`ifdef PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_shift_reg_piso_tx.sv
// Scoreboard bench for shift_reg_piso_tx: MSB-first and LSB-first
// instances share stimulus; expected bits are queued on each accept.
module tb_shift_reg_piso_tx;

  localparam int W = 4;
`ifdef PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  typedef struct packed {
    logic b;
    logic f;
    logic l;
  } ent_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load_valid = 1'b0;
  logic [W-1:0] data_in = '0;

  logic m_ready, m_out, m_valid, m_first, m_last, m_busy;
  logic l_ready, l_out, l_valid, l_first, l_last, l_busy;

  int   checks = 0;
  int   errors = 0;
  ent_t qm[$];
  ent_t ql[$];
  ent_t em, el;
  logic exp_ready;

  always #5 clk = ~clk;

  shift_reg_piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_ready(m_ready),
    .data_in(data_in), .ser_out(m_out),
    .ser_valid(m_valid), .ser_first(m_first),
    .ser_last(m_last), .busy(m_busy)
  );

  shift_reg_piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_ready(l_ready),
    .data_in(data_in), .ser_out(l_out),
    .ser_valid(l_valid), .ser_first(l_first),
    .ser_last(l_last), .busy(l_busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [W-1:0] d);
    ent_t e;
    for (int i = 0; i < W; i++) begin
      e.f = (i == 0);
      e.l = (i == W - 1) && (NB == W);
      e.b = d[W-1-i];
      qm.push_back(e);
      e.b = d[i];
      ql.push_back(e);
    end
`ifdef PARITY_EN
    e.f = 1'b0;
    e.l = 1'b1;
    e.b = ^d;
    qm.push_back(e);
    ql.push_back(e);
`endif
  endtask

  task automatic cyc(input logic v, input logic [W-1:0] d);
    @(posedge clk);
    #1;
    load_valid = v;
    data_in    = d;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_m_ready"}, m_ready, 1'b1);
    chk({tag, "_l_ready"}, l_ready, 1'b1);
    chk({tag, "_m_outs"},
        {m_out, m_valid, m_first, m_last, m_busy}, 5'b0);
    chk({tag, "_l_outs"},
        {l_out, l_valid, l_first, l_last, l_busy}, 5'b0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      exp_ready = (qm.size() == 0) || qm[0].l;
      chk("m_ready", m_ready, exp_ready);
      chk("l_ready", l_ready, exp_ready);
      chk("m_valid", m_valid, qm.size() != 0);
      chk("l_valid", l_valid, ql.size() != 0);
      chk("m_busy", m_busy, qm.size() != 0);
      chk("l_busy", l_busy, ql.size() != 0);
      if (qm.size() != 0 && ql.size() != 0) begin
        em = qm.pop_front();
        el = ql.pop_front();
        chk("m_bit", {m_out, m_first, m_last}, em);
        chk("l_bit", {l_out, l_first, l_last}, el);
      end else begin
        chk("m_idle_out", m_out, 1'b0);
        chk("l_idle_out", l_out, 1'b0);
      end
      if (load_valid && exp_ready)
        push(data_in);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk_idle("in_reset");
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (2) cyc(1'b0, '0);

    // Single frame
    cyc(1'b1, 4'b1101);
    repeat (NB + 2) cyc(1'b0, '0);

    // Back-to-back: next word held until taken on the last bit
    cyc(1'b1, 4'b1101);
    repeat (NB) cyc(1'b1, 4'b0110);
    repeat (NB + 2) cyc(1'b0, '0);

    // Changing data while not ready must be ignored
    cyc(1'b1, 4'b1011);
    repeat (NB - 1) cyc(1'b1, W'($urandom));
    cyc(1'b1, 4'b0110);
    repeat (NB + 2) cyc(1'b0, '0);

    // Random back-to-back traffic
    for (int k = 0; k < 20; k++)
      cyc(1'($urandom), W'($urandom));
    repeat (2 * NB + 2) cyc(1'b0, '0);

    // Asynchronous reset mid-frame after bit 2
    cyc(1'b1, 4'b1011);
    cyc(1'b0, '0);
    cyc(1'b0, '0);
    #7;
    rst_n = 1'b0;
    #1;
    chk_idle("mid_rst");
    qm.delete();
    ql.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    chk_idle("post_rst");
    cyc(1'b1, 4'b0001);
    repeat (NB + 3) cyc(1'b0, '0);

    chk("m_queue_empty", qm.size(), 0);
    chk("l_queue_empty", ql.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_reg_piso_tx.md
Name: shift_reg_piso_tx

Overview:
Parallel-in serial-out transmitter. Accepts a WIDTH-bit parallel word through a valid/ready handshake and shifts it out one bit per clock, with frame-start and frame-last qualifiers. It is the serializing end of the team's shift-register parallel data path and feeds single-wire links and serial-in parallel-out (SIPO) receivers. It supports back-to-back frames with no idle gap.

Parameters:
- WIDTH, 4, data word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = data_in[WIDTH-1] is sent first; 0 = data_in[0] is sent first.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- load_valid  input  1  data_in holds a word to transmit.
- load_ready  output  1  block can accept a word this cycle.
- data_in  input  WIDTH  parallel word; sampled only on an accepting edge.
- ser_out  output  1  serial data bit.
- ser_valid  output  1  ser_out carries a frame bit this cycle.
- ser_first  output  1  first bit of a frame.
- ser_last  output  1  final bit of a frame; this is the parity bit when PARITY_EN is defined.
- busy  output  1  a frame is in progress (equals ser_valid).

Behaviour:
- Reset (rst_n=0), applied immediately and independent of clk:
  - state = IDLE, shift register = 0, bit counter = 0.
  - ser_out=0, ser_valid=0, ser_first=0, ser_last=0, busy=0.
  - load_ready=1, derived combinationally from state.
- Accept: a word is taken on a rising edge where load_valid && load_ready.
  - data_in is captured into the shift register and the bit counter is cleared.
  - If data_in changes on any other edge, it is ignored.
- States:
  - IDLE: on accept, go to SHIFT; otherwise stay.
  - SHIFT: one bit per cycle for WIDTH cycles. After the final data bit, go to PAR if PARITY_EN is defined. Otherwise go to SHIFT (new frame accepted) or IDLE (no new frame).
  - PAR: one cycle, then SHIFT or IDLE by the same rule.
- Latency: first bit appears on ser_out in the cycle after the accepting edge, with ser_valid=1 and ser_first=1.
- Frame length: each bit is held exactly one cycle.
  - WIDTH cycles without PARITY_EN.
  - WIDTH+1 cycles with PARITY_EN.
- load_ready is 1 in IDLE and during the final bit cycle (ser_last=1); it is 0 otherwise.
- Back-to-back: accepting during the final bit cycle starts the next frame's first bit in the immediately following cycle. There are no gap cycles, and ser_first follows ser_last directly.
- Idle outputs: ser_out=0 and ser_valid=0 whenever no frame is active.
- load_valid while load_ready=0: no effect, no capture, no error. The upstream side must hold the word until ready.
- Mid-frame reset: the frame is aborted with no partial completion. After release, the block is in IDLE with load_ready=1.
- Bit counter: sized to $clog2(WIDTH+1) bits, and never wraps past the final bit.

Optional Feature:
PARITY_EN
- Defined:
  - One extra bit follows the last data bit.
  - That bit is the XOR of all WIDTH captured bits (even parity), so the frame including the parity bit has an even number of ones.
  - ser_last marks the parity bit, not the last data bit.
- Undefined:
  - There is no PAR state, frames are WIDTH bits long, and ser_last marks the last data bit.

Test Plan:
- WIDTH=4, MSB_FIRST=1, load 4'b1101 -> ser_out 1,1,0,1 on 4 consecutive cycles starting the cycle after accept. ser_first on bit 1, ser_last on bit 4, then ser_valid=0 and load_ready=1.
- MSB_FIRST=0, load 4'b1101 -> ser_out 1,0,1,1.
- Back-to-back: 4'b1101 accepted, then 4'b0110 presented and accepted during the ser_last cycle -> 8 contiguous valid bits 1,1,0,1,0,1,1,0 with no idle cycle. ser_first is asserted on bit 5.
- Hold load_valid=1 with a changing data_in during bits 1-3 -> load_ready=0, the frame is unchanged, and the new word is accepted only in the ser_last cycle.
- Assert rst_n=0 asynchronously after bit 2 of 4'b1011 -> all outputs go to 0 immediately and load_ready=1. After release, a load of 4'b0001 transmits cleanly as 0,0,0,1.
- PARITY_EN defined:
  - load 4'b1101 -> 1,1,0,1,1, with ser_last on the 5th bit (the parity bit = 1).
  - load 4'b0110 -> parity bit = 0.
